// File: rtl/sa_pkg.sv
// Shared sizing helpers, default geometry and state encoding for the
// systolic tile scheduler and its skew feeder.
package sa_pkg;

  localparam int SA_WIDTH = 8;
  localparam int SA_N     = 4;

  function automatic int acc_w(input int width);
    return 2 * width + 2;
  endfunction

  function automatic int feed_len(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int drain_len(input int n);
    return n;
  endfunction

  localparam int ACC_W     = acc_w(SA_WIDTH);
  localparam int FEED_LEN  = feed_len(SA_N);
  localparam int DRAIN_LEN = drain_len(SA_N);

  // Scheduler state encoding, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t CLEAR = 3'd1;
  localparam state_t FEED  = 3'd2;
  localparam state_t DRAIN = 3'd3;
  localparam state_t DONE  = 3'd4;

endpackage

// File: rtl/sa_tile_scheduler_if.sv
// Job and PE-grid signal bundle for the tile scheduler; the slave modport is
// the scheduler's view, the master modport is the surrounding logic's view.
interface sa_tile_scheduler_if
  import sa_pkg::*;
#(
  parameter int WIDTH      = SA_WIDTH,
  parameter int ARRAY_SIZE = SA_N
) ();

  localparam int OP_W  = WIDTH * ARRAY_SIZE * ARRAY_SIZE;
  localparam int LN_W  = WIDTH * ARRAY_SIZE;
  localparam int RES_W = acc_w(WIDTH) * ARRAY_SIZE * ARRAY_SIZE;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in1;
  logic [OP_W-1:0]  in2;
  logic             pe_clear;
  logic [LN_W-1:0]  left;
  logic [LN_W-1:0]  up;
  logic [RES_W-1:0] sum;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] result;
  logic             busy;

  modport slave (
    input  in_valid, in1, in2, sum, out_ready,
    output in_ready, pe_clear, left, up, out_valid, result, busy
  );

  modport master (
    output in_valid, in1, in2, sum, out_ready,
    input  in_ready, pe_clear, left, up, out_valid, result, busy
  );

endinterface

// File: rtl/sa_skew_feeder.sv
// Registered skewed edge feeds for the systolic grid: lane i of left carries
// A[i][step-i], lane j of up carries B[step-j][j], zero when disabled.
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int WIDTH      = SA_WIDTH,
  parameter int ARRAY_SIZE = SA_N,
  parameter int STEP_W     = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] a,
  input  logic [WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] b,
  input  logic [STEP_W-1:0]                   step,
  input  logic                                en,
  output logic [WIDTH*ARRAY_SIZE-1:0]         left,
  output logic [WIDTH*ARRAY_SIZE-1:0]         up
);

  logic [WIDTH*ARRAY_SIZE-1:0] left_d;
  logic [WIDTH*ARRAY_SIZE-1:0] up_d;

  // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
  always_comb begin
    left_d = '0;
    up_d   = '0;
    if (en) begin
      for (int l = 0; l < ARRAY_SIZE; l++) begin
        if (int'(step) >= l && int'(step) - l < ARRAY_SIZE) begin
          left_d[l*WIDTH +: WIDTH] = a[(l*ARRAY_SIZE + int'(step) - l)*WIDTH +: WIDTH];
          up_d[l*WIDTH +: WIDTH]   = b[((int'(step) - l)*ARRAY_SIZE + l)*WIDTH +: WIDTH];
        end
      end
    end
  end

  // NOTE: flops use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left <= '0;
      up   <= '0;
    end else begin
      left <= left_d;
      up   <= up_d;
    end
  end

endmodule

// File: rtl/sa_tile_scheduler.sv
// Per-job sequencer for the NxN output-stationary systolic grid: accept, clear,
// skewed feed, drain, capture, hold. SA_SCHED_PERF_EN adds job/stall counters.
module sa_tile_scheduler
  import sa_pkg::*;
#(
  parameter int WIDTH      = SA_WIDTH,
  parameter int ARRAY_SIZE = SA_N
) (
  input  logic                clk,
  input  logic                rst,
  sa_tile_scheduler_if.slave  bus
`ifdef SA_SCHED_PERF_EN
  ,
  output logic [15:0]         job_count,
  output logic [31:0]         stall_count
`endif
);

  localparam int OP_W   = WIDTH * ARRAY_SIZE * ARRAY_SIZE;
  localparam int RES_W  = acc_w(WIDTH) * ARRAY_SIZE * ARRAY_SIZE;
  localparam int STEP_W = $clog2(2 * ARRAY_SIZE);
  localparam logic [STEP_W-1:0] FEED_LAST  = STEP_W'(feed_len(ARRAY_SIZE) - 1);
  localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'(drain_len(ARRAY_SIZE) - 1);

  state_t            state;
  logic [STEP_W-1:0] t;
  logic [STEP_W-1:0] step_nxt;
  logic              feed_en_nxt;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic [RES_W-1:0]  result_q;
  logic              done;

  assign done          = (state == DONE);
  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.pe_clear  = (state == CLEAR);
  assign bus.out_valid = done;
  assign bus.result    = result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      t        <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE:  if (bus.in_valid) state <= CLEAR;
        CLEAR: begin
          t     <= '0;
          state <= FEED;
        end
        FEED: begin
          if (t == FEED_LAST) begin
            t     <= '0;
            state <= DRAIN;
          end else begin
            t <= t + 1'b1;
          end
        end
        DRAIN: begin
          if (t == DRAIN_LAST) begin
            t        <= '0;
            result_q <= bus.sum;
            state    <= DONE;
          end else begin
            t <= t + 1'b1;
          end
        end
        DONE:    if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: operand registers are pure data written on every accept before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      a_q <= bus.in1;
      b_q <= bus.in2;
    end
  end

  // The feeder registers its lanes, so it is handed the step of the coming cycle.
  always_comb begin
    feed_en_nxt = 1'b0;
    step_nxt    = '0;
    if (state == CLEAR) begin
      feed_en_nxt = 1'b1;
    end else if (state == FEED && t != FEED_LAST) begin
      feed_en_nxt = 1'b1;
      step_nxt    = t + 1'b1;
    end
  end

  sa_skew_feeder #(
    .WIDTH      (WIDTH),
    .ARRAY_SIZE (ARRAY_SIZE),
    .STEP_W     (STEP_W)
  ) u_feeder (
    .clk  (clk),
    .rst  (rst),
    .a    (a_q),
    .b    (b_q),
    .step (step_nxt),
    .en   (feed_en_nxt),
    .left (bus.left),
    .up   (bus.up)
  );

`ifdef SA_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_count   <= '0;
      stall_count <= '0;
    end else begin
      if (done && bus.out_ready && job_count != 16'hFFFF) job_count <= job_count + 16'd1;
      if (done && !bus.out_ready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Scoreboard bench for sa_tile_scheduler with a behavioural 4x4 PE grid;
// expected products are hand-derived closed forms, checked by a monitor.
module tb_sa_tile_scheduler;
  import sa_pkg::*;

  localparam int W     = 8;
  localparam int N     = 4;
  localparam int AW    = acc_w(W);
  localparam int OP_W  = W * N * N;
  localparam int RES_W = AW * N * N;

  typedef enum int {
    M_ID, M_SEQ, M_NEG, M_ONE, M_TWO, M_THREE_I, M_SKEW, M_ZERO,
    M_ROW, M_COLM1, M_R65536, M_R4, M_R6, M_RBP
  } mat_e;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sa_tile_scheduler_if #(.WIDTH(W), .ARRAY_SIZE(N)) bus ();

`ifdef SA_SCHED_PERF_EN
  logic [15:0] job_count;
  logic [31:0] stall_count;
`endif

  sa_tile_scheduler #(.WIDTH(W), .ARRAY_SIZE(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SA_SCHED_PERF_EN
    ,
    .job_count   (job_count),
    .stall_count (stall_count)
`endif
  );

  // Behavioural PE grid: pass-through registers plus accumulate/clear.
  logic signed [W-1:0]  rq  [N][N];
  logic signed [W-1:0]  dq  [N][N];
  logic signed [AW-1:0] acc [N][N];

  function automatic logic signed [W-1:0] lin(input int i, input int j);
    return (j == 0) ? bus.left[i*W +: W] : rq[i][j-1];
  endfunction

  function automatic logic signed [W-1:0] uin(input int i, input int j);
    return (i == 0) ? bus.up[j*W +: W] : dq[i-1][j];
  endfunction

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        rq[i][j] = '0; dq[i][j] = '0; acc[i][j] = '0;
      end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        rq[i][j]  <= lin(i, j);
        dq[i][j]  <= uin(i, j);
        acc[i][j] <= bus.pe_clear ? '0 : acc[i][j] + AW'(lin(i, j)) * AW'(uin(i, j));
      end
  end

  always_comb begin
    bus.sum = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.sum[(i*N+j)*AW +: AW] = acc[i][j];
  end

  // Hand-derived matrix element tables (operands and closed-form products).
  function automatic int elem(input mat_e kind, input int r, input int c);
    case (kind)
      M_ID:      return (r == c) ? 1 : 0;
      M_SEQ:     return 4*r + c + 1;
      M_NEG:     return -128;
      M_ONE:     return 1;
      M_TWO:     return 2;
      M_THREE_I: return (r == c) ? 3 : 0;
      M_SKEW:    return 16*r + c;
      M_ROW:     return r + 1;
      M_COLM1:   return c - 1;
      M_R65536:  return 65536;
      M_R4:      return 4;
      M_R6:      return 6;
      M_RBP:     return 4*(r + 1)*(c - 1);
      default:   return 0;
    endcase
  endfunction

  function automatic logic [OP_W-1:0] op_mat(input mat_e kind);
    logic [OP_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[(i*N+j)*W +: W] = W'(elem(kind, i, j));
    return r;
  endfunction

  function automatic logic [RES_W-1:0] res_mat(input mat_e kind);
    logic [RES_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[(i*N+j)*AW +: AW] = AW'(elem(kind, i, j));
    return r;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;
  logic [RES_W-1:0] exp_q [$];

  task automatic check(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Monitor: pops the scoreboard on every result handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) flag("unexpected_result");
        else check("result", bus.result, exp_q.pop_front());
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  bus.in_ready,  1);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_pe_clear"},  bus.pe_clear,  0);
    check({tag, "_left"},      bus.left,      0);
    check({tag, "_up"},        bus.up,        0);
    check({tag, "_result"},    bus.result,    0);
`ifdef SA_SCHED_PERF_EN
    check({tag, "_job_count"},   job_count,   0);
    check({tag, "_stall_count"}, stall_count, 0);
`endif
  endtask

  // Returns at the negedge of the accepting cycle H (caller is negedge-aligned).
  task automatic send(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                      input bit push, input logic [RES_W-1:0] exp);
    if (push) exp_q.push_back(exp);
    bus.in1      = a;
    bus.in2      = b;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (bus.in_ready) return;
      @(negedge clk);
    end
    flag("accept_timeout");
  endtask

  // k is the cycle offset from H at the current negedge.
  task automatic wait_valid(inout int k);
    while (!bus.out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!bus.out_valid) flag("out_valid_timeout");
  endtask

  int k;
  int exp_l [7] = '{0, 0, 32, 33, 34, 35, 0};

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.out_ready = 1'b1;
    #1;
    check_reset("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Back-pressure: result held 20 cycles with in_ready low.
    bus.out_ready = 1'b0;
    send(op_mat(M_ROW), op_mat(M_COLM1), 1'b1, res_mat(M_RBP));
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 1;
    wait_valid(k);
    check("bp_latency", k, 13);
    for (int i = 0; i < 20; i++) begin
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_result", bus.result, res_mat(M_RBP));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
`ifdef SA_SCHED_PERF_EN
    check("bp_stall_count", stall_count, 20);
    check("bp_job_count", job_count, 1);
`endif

    // Identity: latency, clear pulse, single-cycle DONE.
    send(op_mat(M_ID), op_mat(M_SEQ), 1'b1, res_mat(M_SEQ));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("id_pe_clear", bus.pe_clear, 1);
    k = 1;
    wait_valid(k);
    check("id_latency", k, 13);
    @(negedge clk);
    check("id_done_one_cycle", bus.out_valid, 0);
    check("id_in_ready_after", bus.in_ready, 1);

    // Skew: left lane 2 over the feed window, B=0 gives zero result.
    send(op_mat(M_SKEW), op_mat(M_ZERO), 1'b1, res_mat(M_ZERO));
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int s = 0; s < 7; s++) begin
      logic [W-1:0] lane_exp;
      lane_exp = W'(exp_l[s]);
      @(negedge clk);
      check($sformatf("skew_left2_t%0d", s), bus.left[2*W +: W], lane_exp);
    end
    k = 8;
    wait_valid(k);
    check("skew_latency", k, 13);
    @(negedge clk);

    // Full negative operands: 4 * 16384 with no wrap.
    send(op_mat(M_NEG), op_mat(M_NEG), 1'b1, res_mat(M_R65536));
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 1;
    wait_valid(k);
    @(negedge clk);

    // Reset at FEED t=3, then an all-ones job.
    send(op_mat(M_SKEW), op_mat(M_SEQ), 1'b0, '0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    check_reset("mid_feed");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(op_mat(M_ONE), op_mat(M_ONE), 1'b1, res_mat(M_R4));
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 1;
    wait_valid(k);
    @(negedge clk);

    // Back-to-back with in_valid held: second accept right after the first release.
    send(op_mat(M_ONE), op_mat(M_ONE), 1'b1, res_mat(M_R4));
    @(negedge clk);
    bus.in1 = op_mat(M_TWO);
    bus.in2 = op_mat(M_THREE_I);
    k = 1;
    wait_valid(k);
    check("b2b_first_latency", k, 13);
    @(negedge clk);
    check("b2b_in_ready", bus.in_ready, 1);
    send(op_mat(M_TWO), op_mat(M_THREE_I), 1'b1, res_mat(M_R6));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b_pe_clear", bus.pe_clear, 1);
    k = 1;
    wait_valid(k);
    check("b2b_second_latency", k, 13);
    repeat (2) @(negedge clk);

    check("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
